// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : voice_allocator
//  Description : Polyphonic voice scheduler. Takes one decoded MIDI channel
//                message per cycle and maps NOTE_ON events onto NUM_VOICES
//                voice slots: retrigger a voice already holding the note, else
//                use the lowest free voice, else steal the oldest voice. It
//                drives per-voice gate, note, velocity and trigger.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator #(
   parameter int NUM_VOICES = 4,
   parameter int CHANNEL    = 0,
   parameter int OMNI       = 0
) (
   input  logic                      clock_50_000_000,
   input  logic                      reset,
   input  logic                      message_valid,
   input  logic [3:0]                message_status,
   input  logic [3:0]                message_channel,
   input  logic [6:0]                message_data1,
   input  logic [6:0]                message_data2,
   output logic [NUM_VOICES-1:0]     voice_gate,
   output logic [NUM_VOICES-1:0]     voice_trigger,
   output logic [7*NUM_VOICES-1:0]   voice_note,
   output logic [7*NUM_VOICES-1:0]   voice_velocity,
   output logic                      voice_stolen,
   output logic [4:0]                active_count
);

   localparam int                 c_IDX_W         = $clog2(NUM_VOICES);
   localparam logic [3:0]         c_NOTE_ON       = 4'h9;
   localparam logic [3:0]         c_NOTE_OFF      = 4'h8;
   localparam logic [3:0]         c_CONTROL       = 4'hB;
   localparam logic [6:0]         c_ALL_NOTES_OFF = 7'd123;
   localparam logic [c_IDX_W-1:0] c_OLDEST        = c_IDX_W'(NUM_VOICES - 1);

   // Registered per-voice state and outputs
   logic [NUM_VOICES-1:0]              r_gate;
   logic [NUM_VOICES-1:0]              r_trigger;
   logic [NUM_VOICES-1:0][6:0]         r_note;
   logic [NUM_VOICES-1:0][6:0]         r_velocity;
   logic [NUM_VOICES-1:0][c_IDX_W-1:0] r_rank;
   logic                               r_stolen;
   logic [4:0]                         r_active_count;

   // Decoded message intent
   logic w_accept;
   logic w_note_on;
   logic w_note_off;
   logic w_all_off;

   // Victim search results
   logic               w_match_hit;
   logic [c_IDX_W-1:0] w_match_idx;
   logic               w_free_hit;
   logic [c_IDX_W-1:0] w_free_idx;
   logic [c_IDX_W-1:0] w_oldest_idx;
   logic [c_IDX_W-1:0] w_victim;
   logic               w_steal;

   // Next-state values
   logic [NUM_VOICES-1:0]              w_gate_next;
   logic [NUM_VOICES-1:0]              w_trigger_next;
   logic [NUM_VOICES-1:0][6:0]         w_note_next;
   logic [NUM_VOICES-1:0][6:0]         w_velocity_next;
   logic [NUM_VOICES-1:0][c_IDX_W-1:0] w_rank_next;
   logic                               w_stolen_next;
   logic [4:0]                         w_count_next;

   // Decode the incoming message; velocity-zero NOTE_ON is a NOTE_OFF
   always_comb begin
      w_accept   = message_valid &&
                   ((OMNI != 0) || (message_channel == 4'(CHANNEL)));
      w_note_on  = w_accept && (message_status == c_NOTE_ON) &&
                   (message_data2 != 7'd0);
      w_note_off = w_accept &&
                   ((message_status == c_NOTE_OFF) ||
                    ((message_status == c_NOTE_ON) && (message_data2 == 7'd0)));
      w_all_off  = w_accept && (message_status == c_CONTROL) &&
                   (message_data1 == c_ALL_NOTES_OFF);
   end

   // Victim search: held note first, then lowest free voice, then oldest voice
   always_comb begin
      w_match_hit  = 1'b0;
      w_match_idx  = '0;
      w_free_hit   = 1'b0;
      w_free_idx   = '0;
      w_oldest_idx = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         // At most one gated voice can hold a given note.
         if (r_gate[i] && (r_note[i] == message_data1)) begin
            w_match_hit = 1'b1;
            w_match_idx = c_IDX_W'(i);
         end
         if (r_rank[i] == c_OLDEST) begin
            w_oldest_idx = c_IDX_W'(i);
         end
      end
      // Scan downward so the lowest free index is the last one written.
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (!r_gate[i]) begin
            w_free_hit = 1'b1;
            w_free_idx = c_IDX_W'(i);
         end
      end
      w_steal = 1'b0;
      if (w_match_hit) begin
         w_victim = w_match_idx;
      end else if (w_free_hit) begin
         w_victim = w_free_idx;
      end else begin
         w_victim = w_oldest_idx;
         w_steal  = 1'b1;
      end
   end

   // Compute the next voice state for the accepted message
   always_comb begin
      w_gate_next     = r_gate;
      w_note_next     = r_note;
      w_velocity_next = r_velocity;
      w_rank_next     = r_rank;
      w_trigger_next  = '0;
      w_stolen_next   = 1'b0;
      if (w_note_on) begin
         w_stolen_next = w_steal;
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (c_IDX_W'(i) == w_victim) begin
               w_gate_next[i]     = 1'b1;
               w_note_next[i]     = message_data1;
               w_velocity_next[i] = message_data2;
               w_trigger_next[i]  = 1'b1;
               w_rank_next[i]     = '0;
            end else if (r_rank[i] < r_rank[w_victim]) begin
               // Voices newer than the victim each age by one step.
               w_rank_next[i] = r_rank[i] + c_IDX_W'(1);
            end
         end
      end else if (w_note_off) begin
         // Note and velocity hold so the envelope can release.
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (r_gate[i] && (r_note[i] == message_data1)) begin
               w_gate_next[i] = 1'b0;
            end
         end
      end else if (w_all_off) begin
         w_gate_next = '0;
      end
      w_count_next = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         w_count_next = w_count_next + 5'(w_gate_next[i]);
      end
   end

   // Register voice state; reset restores the identity age ordering
   always_ff @(posedge clock_50_000_000) begin
      if (reset) begin
         r_gate         <= '0;
         r_trigger      <= '0;
         r_note         <= '0;
         r_velocity     <= '0;
         r_stolen       <= 1'b0;
         r_active_count <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_rank[i] <= c_IDX_W'(i);
         end
      end else begin
         r_gate         <= w_gate_next;
         r_trigger      <= w_trigger_next;
         r_note         <= w_note_next;
         r_velocity     <= w_velocity_next;
         r_rank         <= w_rank_next;
         r_stolen       <= w_stolen_next;
         r_active_count <= w_count_next;
      end
   end

   assign voice_gate     = r_gate;
   assign voice_trigger  = r_trigger;
   assign voice_note     = r_note;
   assign voice_velocity = r_velocity;
   assign voice_stolen   = r_stolen;
   assign active_count   = r_active_count;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voice_allocator
//  Description : Scoreboard bench for voice_allocator. A reference model of
//                the allocation rules predicts the outputs for every driven
//                cycle; a monitor compares the DUT one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

   localparam int N = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             message_valid;
   logic [3:0]       message_status;
   logic [3:0]       message_channel;
   logic [6:0]       message_data1;
   logic [6:0]       message_data2;
   logic [N-1:0]     voice_gate;
   logic [N-1:0]     voice_trigger;
   logic [7*N-1:0]   voice_note;
   logic [7*N-1:0]   voice_velocity;
   logic             voice_stolen;
   logic [4:0]       active_count;

   voice_allocator #(
      .NUM_VOICES (N),
      .CHANNEL    (0),
      .OMNI       (0)
   ) dut (
      .clock_50_000_000 (clk),
      .reset            (reset),
      .message_valid    (message_valid),
      .message_status   (message_status),
      .message_channel  (message_channel),
      .message_data1    (message_data1),
      .message_data2    (message_data2),
      .voice_gate       (voice_gate),
      .voice_trigger    (voice_trigger),
      .voice_note       (voice_note),
      .voice_velocity   (voice_velocity),
      .voice_stolen     (voice_stolen),
      .active_count     (active_count)
   );

   always #10 clk = ~clk;

   typedef struct packed {
      logic [N-1:0]   gate;
      logic [N-1:0]   trig;
      logic [7*N-1:0] note;
      logic [7*N-1:0] vel;
      logic           stolen;
      logic [4:0]     cnt;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: voice contents plus an age list, newest first
   bit m_gate[N];
   int m_note[N];
   int m_vel[N];
   int m_order[$];

   task automatic model_step(input bit rst, input bit v, input int s,
                             input int c, input int a, input int b);
      exp_t e;
      bit   trig[N];
      bit   stolen;
      int   victim;
      int   cnt;
      for (int i = 0; i < N; i++) trig[i] = 0;
      stolen = 0;
      if (rst) begin
         m_order.delete();
         for (int i = 0; i < N; i++) begin
            m_gate[i] = 0;
            m_note[i] = 0;
            m_vel[i]  = 0;
            m_order.push_back(i);
         end
      end else if (v && c == 0) begin
         if (s == 9 && b != 0) begin
            victim = -1;
            for (int i = 0; i < N; i++)
               if (m_gate[i] && m_note[i] == a) victim = i;
            if (victim < 0)
               for (int i = N - 1; i >= 0; i--)
                  if (!m_gate[i]) victim = i;
            if (victim < 0) begin
               victim = m_order[m_order.size() - 1];
               stolen = 1;
            end
            m_gate[victim] = 1;
            m_note[victim] = a;
            m_vel[victim]  = b;
            trig[victim]   = 1;
            for (int k = 0; k < m_order.size(); k++)
               if (m_order[k] == victim) begin
                  m_order.delete(k);
                  break;
               end
            m_order.push_front(victim);
         end else if (s == 8 || (s == 9 && b == 0)) begin
            for (int i = 0; i < N; i++)
               if (m_gate[i] && m_note[i] == a) m_gate[i] = 0;
         end else if (s == 'hB && a == 123) begin
            for (int i = 0; i < N; i++) m_gate[i] = 0;
         end
      end
      cnt = 0;
      for (int i = 0; i < N; i++) begin
         e.gate[i]       = m_gate[i];
         e.trig[i]       = trig[i];
         e.note[7*i +: 7] = 7'(m_note[i]);
         e.vel[7*i +: 7]  = 7'(m_vel[i]);
         cnt += m_gate[i] ? 1 : 0;
      end
      e.stolen = stolen;
      e.cnt    = 5'(cnt);
      sb.push_back(e);
   endtask

   task automatic drive(input bit rst, input bit v, input int s,
                        input int c, input int a, input int b);
      @(negedge clk);
      reset           = rst;
      message_valid   = v;
      message_status  = 4'(s);
      message_channel = 4'(c);
      message_data1   = 7'(a);
      message_data2   = 7'(b);
      model_step(rst, v, s, c, a, b);
   endtask

   task automatic note_on(input int a, input int b);
      drive(0, 1, 9, 0, a, b);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest prediction each cycle
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("gate",     64'(voice_gate),     64'(e.gate));
            chk("trigger",  64'(voice_trigger),  64'(e.trig));
            chk("note",     64'(voice_note),     64'(e.note));
            chk("velocity", 64'(voice_velocity), 64'(e.vel));
            chk("stolen",   64'(voice_stolen),   64'(e.stolen));
            chk("count",    64'(active_count),   64'(e.cnt));
         end
      end
   end

   // Stimulus: directed scenarios followed by a randomized stream
   initial begin
      int sel, s, c, a, b;
      bit rst, v;
      reset = 1'b1;
      message_valid = 1'b0;
      message_status = '0;
      message_channel = '0;
      message_data1 = '0;
      message_data2 = '0;

      drive(1, 0, 0, 0, 0, 0);
      idle();
      note_on(60, 100);
      note_on(62, 90);
      note_on(64, 80);
      idle();
      note_on(65, 70);
      note_on(67, 50);          // all voices busy: steal oldest (voice 0)
      idle();
      note_on(67, 40);          // retrigger same voice
      note_on(67, 30);
      drive(0, 1, 8, 0, 62, 0); // NOTE_OFF 62
      drive(0, 1, 9, 0, 64, 0); // NOTE_ON velocity 0 acts as NOTE_OFF
      drive(0, 1, 8, 0, 70, 0); // not held
      note_on(71, 10);          // lowest free voice
      drive(0, 1, 'hB, 0, 7, 99);   // other controller ignored
      drive(0, 1, 'hE, 0, 60, 10);  // unknown status ignored
      drive(0, 1, 'hB, 0, 123, 0);  // all notes off
      note_on(50, 1);
      note_on(51, 2);
      note_on(52, 3);
      note_on(53, 4);
      note_on(54, 127);
      drive(0, 1, 'hB, 0, 123, 0);
      note_on(55, 5);
      drive(0, 1, 9, 3, 60, 100);   // wrong channel ignored
      drive(1, 1, 9, 0, 70, 70);    // reset mid-stream drops this message
      note_on(72, 72);
      idle();

      for (int k = 0; k < 800; k++) begin
         rst = ($urandom_range(0, 99) < 2);
         v   = ($urandom_range(0, 9) != 0);
         sel = $urandom_range(0, 9);
         s   = (sel < 5) ? 9 : (sel < 8) ? 8 : (sel == 8) ? 'hB : $urandom_range(0, 15);
         c   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : 0;
         a   = 60 + $urandom_range(0, 7);
         if (s == 'hB && $urandom_range(0, 1) == 0) a = 123;
         b   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 127);
         drive(rst, v, s, c, a, b);
      end
      idle();

      for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
      #2;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: actual=%0d pending required=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
